imm_const_sequencer: RTL and testbench
======================================

// Module: imm_const_sequencer
// PURPOSE
//  Multi-cycle sequencer that builds an arbitrary 64-bit constant by driving the
//  immediate sign extender through its MOVZ modes, one 16-bit halfword per cycle.
//  MOVZ Ctrl codes are 3'b100..3'b111: Imm[20:5] is placed at LSL 0/16/32/48, all
//  other bits are zero. This block owns the extender's Ctrl/Imm inputs while busy.
//  It ORs the extender outputs into an accumulator (MOVZ then MOVK semantics).
//  It sits between the constant-load request source and the register write path.
// PARAMETERS
//  SKIP_ZERO  1  1: skip all-zero halfwords; 0: always issue all four slots
// PORTS
//  Clk        in   1   clock; all state updates on rising edge
//  Reset      in   1   synchronous, active-high reset
//  ReqValid   in   1   constant request valid
//  ReqData    in   64  constant to build
//  ReqReady   out  1   request accepted when ReqValid & ReqReady
//  ExtImm     out  26  to extender Imm; halfword on [20:5], all other bits 0
//  ExtCtrl    out  3   to extender Ctrl; {1'b1, slot[1:0]} while issuing
//  ExtBus     in   64  extender BusImm (combinational from ExtImm/ExtCtrl)
//  ExtActive  out  1   high in every cycle an op is issued to the extender
//  RespValid  out  1   built constant valid
//  RespData   out  64  built constant; stable while RespValid & !RespReady
//  RespReady  in   1   response consumed when RespValid & RespReady
//  OpCount    out  3   number of extender ops used for the current result (1..4)
// BEHAVIOUR
//  Reset (synchronous): state=IDLE; ReqReady=1; RespValid=0; RespData=0; OpCount=0;
//   ExtActive=0; ExtCtrl=3'b000; ExtImm=0; mask=0; Reset wins over all other inputs.
//  FSM states: IDLE, ISSUE, DONE.
//  IDLE: ReqReady=1. On ReqValid, capture ReqData. Set mask[i]=(halfword i != 0) if
//   SKIP_ZERO=1, else mask=4'b1111. If mask==0, force mask=4'b0001 (a single MOVZ of 0).
//   Clear OpCount and set first=1, then go to ISSUE.
//  ISSUE: ReqReady=0. slot = lowest set bit of mask. Drive ExtCtrl={1'b1,slot},
//   ExtImm[20:5]=ReqData[16*slot+15:16*slot], ExtActive=1.
//   On the edge: acc <= (first ? 64'b0 : acc) | ExtBus; clear mask[slot]; first<=0;
//   OpCount <= OpCount+1.
//   If mask had exactly one bit set, go to DONE; otherwise stay in ISSUE.
//  DONE: RespValid=1; RespData=acc; ReqReady=0. On RespReady, go to IDLE.
//   A new request is accepted no earlier than the cycle after the response handshake.
//  Outside ISSUE, ExtCtrl=3'b000, ExtImm=0 and ExtActive=0 (extender idle/shared).
//  Latency: accept at cycle T; issues at T+1..T+N where N=popcount(mask) (1..4);
//   RespValid rises at T+N+1.
//  Width rule: slots are disjoint, so OR accumulation is exact. RespData==ReqData
//   for every input, for both SKIP_ZERO settings.
//  Backpressure: RespData and OpCount hold while RespReady=0; no timeout.
//  Reset mid-ISSUE or mid-DONE: partial result and pending response are discarded.
// TESTING
//  ReqData=64'h0 -> one issue with ExtCtrl=3'b100, ExtImm=0; RespData=0, OpCount=1,
//   RespValid at T+2.
//  ReqData=64'h1234_0000_0000_ABCD -> issues Ctrl 3'b100 (ImmHW 16'hABCD), then
//   3'b111 (16'h1234); RespData=64'h1234_0000_0000_ABCD, OpCount=2.
//  ReqData=64'hFFFF_FFFF_FFFF_FFFF -> four issues, Ctrl 100,101,110,111 in order;
//   OpCount=4; RespValid at T+5.
//  Hold RespReady=0 for 5 cycles in DONE -> RespData stable, ReqReady=0, ExtActive=0;
//   after RespReady=1, IDLE on the next cycle.
//  Reset=1 during the 2nd issue of 64'h0001_0002_0003_0004 -> next cycle all outputs at
//   reset values; a following request of 64'h5 -> RespData=5, OpCount=1.
//  SKIP_ZERO=0, ReqData=64'h0000_0001_0000_0000 -> four issues; RespData matches input;
//   OpCount=4.

Source files
------------

// File: rtl/imm_const_sequencer.sv
// -----------------------------------------------------------------------------
// imm_const_sequencer
//
// Builds an arbitrary 64-bit constant by driving the immediate sign extender
// through its MOVZ modes, one 16-bit halfword per cycle. The extender result
// for each halfword is ORed into an accumulator. The first op clears the
// accumulator (MOVZ) and the following ops merge into it (MOVK). The halfword
// slots are disjoint, so the OR accumulation reproduces the request exactly.
//
// Ports
//   Clk        in   1   clock, all state updates on the rising edge
//   Reset      in   1   synchronous, active-high reset (wins over everything)
//   ReqValid   in   1   constant request valid
//   ReqData    in   64  constant to build
//   ReqReady   out  1   request accepted when ReqValid & ReqReady
//   ExtImm     out  26  extender Imm; halfword on [20:5], other bits zero
//   ExtCtrl    out  3   extender Ctrl; {1'b1, slot} while issuing, else 0
//   ExtBus     in   64  extender BusImm (combinational from ExtImm/ExtCtrl)
//   ExtActive  out  1   high in every cycle an op is issued to the extender
//   RespValid  out  1   built constant valid
//   RespData   out  64  built constant, held while RespValid & !RespReady
//   RespReady  in   1   response consumed when RespValid & RespReady
//   OpCount    out  3   extender ops used for the current result (1..4)
//   DbgState   out  2   current FSM state (0 IDLE, 1 ISSUE, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready of the same interface. Once
// RespValid is raised, it and RespData stay stable until the transfer.
// -----------------------------------------------------------------------------
module imm_const_sequencer #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    input  logic [63:0] ReqData,
    output logic        ReqReady,
    output logic [25:0] ExtImm,
    output logic [2:0]  ExtCtrl,
    input  logic [63:0] ExtBus,
    output logic        ExtActive,
    output logic        RespValid,
    output logic [63:0] RespData,
    input  logic        RespReady,
    output logic [2:0]  OpCount,
    output logic [1:0]  DbgState
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [63:0] req_data;   // captured request
    logic [3:0]  mask;       // halfword slots still to issue
    logic        first;      // next op is the MOVZ that clears the accumulator
    logic [63:0] acc;        // accumulated extender results
    logic [2:0]  op_count;   // ops issued for the current request

    logic [3:0]  init_mask;
    logic [1:0]  slot;
    logic        last_op;
    logic [15:0] slot_hw;

    // Slots to issue for an incoming request. An all-zero constant still
    // needs one MOVZ of zero so the destination is written.
    always_comb begin
        init_mask = 4'b1111;
        if (SKIP_ZERO) begin
            for (int i = 0; i < 4; i++) begin
                init_mask[i] = |ReqData[16*i +: 16];
            end
        end
        if (init_mask == 4'b0000) begin
            init_mask = 4'b0001;
        end
    end

    // Issue order is lowest slot first.
    always_comb begin
        slot = 2'd0;
        if (mask[0]) begin
            slot = 2'd0;
        end else if (mask[1]) begin
            slot = 2'd1;
        end else if (mask[2]) begin
            slot = 2'd2;
        end else if (mask[3]) begin
            slot = 2'd3;
        end
    end

    // Exactly one bit left means this is the final op.
    assign last_op = ((mask & (mask - 4'd1)) == 4'd0);
    assign slot_hw = req_data[{slot, 4'b0000} +: 16];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ReqValid) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (last_op) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (RespReady) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            req_data <= 64'd0;
            mask     <= 4'd0;
            first    <= 1'b0;
            acc      <= 64'd0;
            op_count <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ReqValid) begin
                        req_data <= ReqData;
                        mask     <= init_mask;
                        first    <= 1'b1;
                        op_count <= 3'd0;
                    end
                end
                ST_ISSUE: begin
                    acc      <= (first ? 64'd0 : acc) | ExtBus;
                    mask     <= mask & ~(4'b0001 << slot);
                    first    <= 1'b0;
                    op_count <= op_count + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // The extender is shared, so its inputs are parked at zero whenever
    // this block is not issuing.
    always_comb begin
        ReqReady  = 1'b0;
        ExtImm    = 26'd0;
        ExtCtrl   = 3'b000;
        ExtActive = 1'b0;
        RespValid = 1'b0;
        RespData  = 64'd0;
        case (state)
            ST_IDLE: begin
                ReqReady = 1'b1;
            end
            ST_ISSUE: begin
                ExtImm    = {5'd0, slot_hw, 5'd0};
                ExtCtrl   = {1'b1, slot};
                ExtActive = 1'b1;
            end
            ST_DONE: begin
                RespValid = 1'b1;
                RespData  = acc;
            end
            default: begin
            end
        endcase
    end

    assign OpCount  = op_count;
    assign DbgState = state;

endmodule

// File: tb/tb_imm_const_sequencer.sv
module tb_imm_const_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [63:0] req_data = 64'd0;
  logic        resp_ready = 1'b1;
  logic        sel = 1'b0;  // 0: SKIP_ZERO=1 instance, 1: SKIP_ZERO=0 instance

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- two DUT instances ----------------
  logic        req_valid0, req_valid1, resp_ready0, resp_ready1;
  logic        req_ready0, req_ready1, ext_active0, ext_active1;
  logic        resp_valid0, resp_valid1;
  logic [25:0] ext_imm0, ext_imm1;
  logic [2:0]  ext_ctrl0, ext_ctrl1, op_count0, op_count1;
  logic [63:0] ext_bus0, ext_bus1, resp_data0, resp_data1;
  logic [1:0]  dbg_state0, dbg_state1;

  assign req_valid0  = req_valid & ~sel;
  assign req_valid1  = req_valid & sel;
  assign resp_ready0 = sel ? 1'b1 : resp_ready;
  assign resp_ready1 = sel ? resp_ready : 1'b1;

  // extender MOVZ behaviour: Imm[20:5] at LSL 16*Ctrl[1:0]
  function automatic logic [63:0] ext_model(input logic [25:0] imm, input logic [2:0] ctrl);
    logic [63:0] hw;
    hw = ({38'd0, imm} >> 5) & 64'hFFFF;
    if (ctrl[2]) return hw << (16 * ctrl[1:0]);
    return 64'd0;
  endfunction

  assign ext_bus0 = ext_model(ext_imm0, ext_ctrl0);
  assign ext_bus1 = ext_model(ext_imm1, ext_ctrl1);

  imm_const_sequencer #(.SKIP_ZERO(1'b1)) dut0 (
    .Clk(clk), .Reset(reset), .ReqValid(req_valid0), .ReqData(req_data),
    .ReqReady(req_ready0), .ExtImm(ext_imm0), .ExtCtrl(ext_ctrl0), .ExtBus(ext_bus0),
    .ExtActive(ext_active0), .RespValid(resp_valid0), .RespData(resp_data0),
    .RespReady(resp_ready0), .OpCount(op_count0), .DbgState(dbg_state0)
  );

  imm_const_sequencer #(.SKIP_ZERO(1'b0)) dut1 (
    .Clk(clk), .Reset(reset), .ReqValid(req_valid1), .ReqData(req_data),
    .ReqReady(req_ready1), .ExtImm(ext_imm1), .ExtCtrl(ext_ctrl1), .ExtBus(ext_bus1),
    .ExtActive(ext_active1), .RespValid(resp_valid1), .RespData(resp_data1),
    .RespReady(resp_ready1), .OpCount(op_count1), .DbgState(dbg_state1)
  );

  logic        m_req_ready, m_ext_active, m_resp_valid;
  logic [25:0] m_ext_imm;
  logic [2:0]  m_ext_ctrl, m_op_count;
  logic [63:0] m_resp_data;
  logic [1:0]  m_dbg_state;

  assign m_req_ready  = sel ? req_ready1  : req_ready0;
  assign m_ext_active = sel ? ext_active1 : ext_active0;
  assign m_resp_valid = sel ? resp_valid1 : resp_valid0;
  assign m_ext_imm    = sel ? ext_imm1    : ext_imm0;
  assign m_ext_ctrl   = sel ? ext_ctrl1   : ext_ctrl0;
  assign m_op_count   = sel ? op_count1   : op_count0;
  assign m_resp_data  = sel ? resp_data1  : resp_data0;
  assign m_dbg_state  = sel ? dbg_state1  : dbg_state0;

  // ---------------- scoreboard ----------------
  logic [28:0] exp_ext_q[$];   // {ctrl, imm}
  logic [70:0] exp_resp_q[$];  // {latency, op_count, data}

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops and compares on every extender issue and response transfer
  logic        prev_rv = 1'b0;
  int          acc_cyc = 0;
  logic [28:0] e_ext;
  logic [70:0] e_resp;

  always @(negedge clk) begin
    if (reset) begin
      exp_ext_q.delete();
      exp_resp_q.delete();
      prev_rv = 1'b0;
    end else begin
      if (req_valid && m_req_ready) acc_cyc = cyc;
      if (m_ext_active) begin
        if (exp_ext_q.size() == 0) begin
          check("unexpected_issue", 64'd1, 64'd0);
        end else begin
          e_ext = exp_ext_q.pop_front();
          check("ext_ctrl", 64'(m_ext_ctrl), 64'(e_ext[28:26]));
          check("ext_imm", 64'(m_ext_imm), 64'(e_ext[25:0]));
        end
      end
      if (m_resp_valid && !prev_rv && exp_resp_q.size() != 0) begin
        e_resp = exp_resp_q[0];
        check("latency", 64'(cyc - acc_cyc), 64'(e_resp[70:67]));
      end
      if (m_resp_valid && resp_ready) begin
        if (exp_resp_q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e_resp = exp_resp_q.pop_front();
          check("resp_data", m_resp_data, e_resp[63:0]);
          check("op_count", 64'(m_op_count), 64'(e_resp[66:64]));
        end
      end
      prev_rv = m_resp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // Expected ops: one MOVZ/MOVK per slot in ascending order; zero halfwords
  // are skipped when skip is set; an all-skipped constant uses one MOVZ of 0.
  task automatic send(input logic [63:0] d, input bit skip);
    int n;
    logic [15:0] hw;
    bit ok;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      hw = d[16*i +: 16];
      if (!skip || hw != 16'd0) begin
        exp_ext_q.push_back({1'b1, 2'(i), 5'd0, hw, 5'd0});
        n++;
      end
    end
    if (n == 0) begin
      exp_ext_q.push_back({3'b100, 26'd0});
      n = 1;
    end
    exp_resp_q.push_back({4'(n + 1), 3'(n), d});
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_data  = d;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("req_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (exp_resp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", 64'(m_req_ready), 64'd1);
    check("rst_resp_valid", 64'(m_resp_valid), 64'd0);
    check("rst_resp_data", m_resp_data, 64'd0);
    check("rst_op_count", 64'(m_op_count), 64'd0);
    check("rst_ext_active", 64'(m_ext_active), 64'd0);
    check("rst_ext_ctrl", 64'(m_ext_ctrl), 64'd0);
    check("rst_ext_imm", 64'(m_ext_imm), 64'd0);
    check("rst_state", 64'(m_dbg_state), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    reset = 1'b0;

    // basic vectors
    send(64'h0, 1'b1);                    wait_done();
    send(64'h1234_0000_0000_ABCD, 1'b1);  wait_done();
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);  wait_done();
    send(64'h0000_5A5A_0000_0000, 1'b1);  wait_done();

    // backpressure in DONE
    resp_ready = 1'b0;
    send(64'hDEAD_0000_BEEF_0000, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("hold_resp_data", m_resp_data, 64'hDEAD_0000_BEEF_0000);
      check("hold_op_count", 64'(m_op_count), 64'd2);
      check("hold_req_ready", 64'(m_req_ready), 64'd0);
      check("hold_ext_active", 64'(m_ext_active), 64'd0);
      check("hold_resp_valid", 64'(m_resp_valid), 64'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_after_resp", 64'(m_dbg_state), 64'd0);
    check("ready_after_resp", 64'(m_req_ready), 64'd1);

    // reset during the second issue
    send(64'h0001_0002_0003_0004, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values();
    send(64'h5, 1'b1);  wait_done();

    // no skipping of zero halfwords
    sel = 1'b1;
    send(64'h0000_0001_0000_0000, 1'b0);  wait_done();
    send(64'h0, 1'b0);                    wait_done();
    sel = 1'b0;

    repeat (3) @(negedge clk);
    check("ext_q_empty", 64'(exp_ext_q.size()), 64'd0);
    check("resp_q_empty", 64'(exp_resp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
